// File: rtl/spi_sync_filter.sv
// spi_sync_filter: per-channel input conditioner for asynchronous pins.
// Each channel has a STAGES-deep synchroniser and a glitch filter that
// only accepts a new level after FILTER_LEN consecutive matching samples.
// It also produces registered one-cycle rise/fall strobes on the filtered level.
module spi_sync_filter #(
    parameter int unsigned           WIDTH      = 4,
    parameter int unsigned           STAGES     = 2,
    parameter int unsigned           FILTER_LEN = 3,
    parameter logic [WIDTH-1:0]      RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned    CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    if (STAGES < 2) begin : g_bad_stages
        $error("spi_sync_filter: STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("spi_sync_filter: FILTER_LEN must be at least 1");
    end

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] synced;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    next_cnt [WIDTH];
    logic [WIDTH-1:0] next_out;

    assign synced = chain[STAGES-1];

    // Synchroniser chain: plain flop-to-flop, loaded with RESET_VAL on reset
    // so releasing reset cannot create an edge from stale chain contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                chain[k] <= RESET_VAL;
            end
        end else begin
            chain[0] <= async_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

    // Filter next-state: any sample equal to the current output restarts the count.
    always_comb begin
        next_out = sync_out;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            next_cnt[i] = '0;
            if (synced[i] != sync_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    next_out[i] = synced[i];
                end else begin
                    next_cnt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Filter state, filtered level and edge strobes, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_out <= RESET_VAL;
            rise     <= '0;
            fall     <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_out <= next_out;
            rise     <= next_out & ~sync_out;
            fall     <= ~next_out & sync_out;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= next_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_sync_filter.sv
// Testbench for spi_sync_filter: table-driven per-edge expectations fed
// through a scoreboard queue. It covers a default build and an alternate
// build with STAGES=3, FILTER_LEN=1 and RESET_VAL=4'hF.
module tb_spi_sync_filter;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] in_a, in_b;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  din;
        int unsigned n;
        logic [3:0]  out;
        logic [3:0]  rise;
        logic [3:0]  fall;
    } vec_t;

    typedef struct {
        bit          sel;
        logic [3:0]  out;
        logic [3:0]  rise;
        logic [3:0]  fall;
        string       tag;
    } exp_t;

    exp_t sb[$];

    spi_sync_filter #(
        .WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(4'h0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .async_in(in_a),
        .sync_out(out_a), .rise(rise_a), .fall(fall_a)
    );

    spi_sync_filter #(
        .WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'hF)
    ) dut_b (
        .clk(clk), .rst(rst_b), .async_in(in_b),
        .sync_out(out_b), .rise(rise_b), .fall(fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Drive one edge's inputs, queue its expectation, then compare #1 after the edge.
    task automatic step(input bit sel, input logic r, input logic [3:0] d,
                        input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                        input string tag);
        exp_t       e;
        logic [3:0] go, gr, gf;
        if (sel) begin
            rst_b = r; in_b = d;
        end else begin
            rst_a = r; in_a = d;
        end
        sb.push_back('{sel, eo, er, ef, tag});
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        go = e.sel ? out_b  : out_a;
        gr = e.sel ? rise_b : rise_a;
        gf = e.sel ? fall_b : fall_a;
        check({e.tag, "_out"},  go, e.out);
        check({e.tag, "_rise"}, gr, e.rise);
        check({e.tag, "_fall"}, gf, e.fall);
        check({e.tag, "_excl"}, gr & gf, 4'h0);
    endtask

    task automatic run_table(input bit sel, input string pfx, input vec_t v[$]);
        for (int r = 0; r < v.size(); r++) begin
            for (int unsigned c = 0; c < v[r].n; c++) begin
                step(sel, v[r].rst, v[r].din, v[r].out, v[r].rise, v[r].fall,
                     $sformatf("%s_row%0d_cyc%0d", pfx, r, c));
            end
        end
    endtask

    initial begin
        vec_t va[$];
        vec_t vb[$];

        // Default build (STAGES=2, FILTER_LEN=3): changes land 5 edges after the input.
        // rst, din, edges, sync_out, rise, fall
        va.push_back('{1'b1, 4'hF, 2, 4'h0, 4'h0, 4'h0}); // held in reset
        va.push_back('{1'b0, 4'hF, 4, 4'h0, 4'h0, 4'h0}); // release
        va.push_back('{1'b0, 4'hF, 1, 4'hF, 4'hF, 4'h0}); // 5th edge
        va.push_back('{1'b0, 4'hF, 2, 4'hF, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h8, 4, 4'hF, 4'h0, 4'h0}); // settle to ch3 high only
        va.push_back('{1'b0, 4'h8, 1, 4'h8, 4'h0, 4'h7});
        va.push_back('{1'b0, 4'h8, 2, 4'h8, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h9, 4, 4'h8, 4'h0, 4'h0}); // clean step on ch0
        va.push_back('{1'b0, 4'h9, 1, 4'h9, 4'h1, 4'h0});
        va.push_back('{1'b0, 4'h9, 3, 4'h9, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h8, 4, 4'h9, 4'h0, 4'h0}); // and back
        va.push_back('{1'b0, 4'h8, 1, 4'h8, 4'h0, 4'h1});
        va.push_back('{1'b0, 4'h8, 2, 4'h8, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'hA, 2, 4'h8, 4'h0, 4'h0}); // 2-cycle glitch on ch1
        va.push_back('{1'b0, 4'h8, 6, 4'h8, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'hA, 3, 4'h8, 4'h0, 4'h0}); // 3-cycle high on ch1
        va.push_back('{1'b0, 4'h8, 1, 4'h8, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h8, 1, 4'hA, 4'h2, 4'h0});
        va.push_back('{1'b0, 4'h8, 2, 4'hA, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h8, 1, 4'h8, 4'h0, 4'h2});
        va.push_back('{1'b0, 4'h8, 2, 4'h8, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h4, 4, 4'h8, 4'h0, 4'h0}); // ch2 up, ch3 down together
        va.push_back('{1'b0, 4'h4, 1, 4'h4, 4'h4, 4'h8});
        va.push_back('{1'b0, 4'h4, 2, 4'h4, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h5, 4, 4'h4, 4'h0, 4'h0}); // ch0 rises, count reaches 2
        va.push_back('{1'b1, 4'h5, 1, 4'h0, 4'h0, 4'h0}); // reset on the would-be update edge
        va.push_back('{1'b0, 4'h5, 4, 4'h0, 4'h0, 4'h0});
        va.push_back('{1'b0, 4'h5, 1, 4'h5, 4'h5, 4'h0});
        va.push_back('{1'b0, 4'h5, 2, 4'h5, 4'h0, 4'h0});

        // Alternate build (STAGES=3, FILTER_LEN=1, RESET_VAL=F): changes land 4 edges later.
        vb.push_back('{1'b1, 4'hF, 2, 4'hF, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hF, 3, 4'hF, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hE, 3, 4'hF, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hE, 1, 4'hE, 4'h0, 4'h1});
        vb.push_back('{1'b0, 4'hE, 2, 4'hE, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hF, 3, 4'hE, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hF, 1, 4'hF, 4'h1, 4'h0});
        vb.push_back('{1'b0, 4'hF, 2, 4'hF, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hE, 1, 4'hF, 4'h0, 4'h0}); // single-cycle low pulse
        vb.push_back('{1'b0, 4'hF, 2, 4'hF, 4'h0, 4'h0});
        vb.push_back('{1'b0, 4'hF, 1, 4'hE, 4'h0, 4'h1});
        vb.push_back('{1'b0, 4'hF, 1, 4'hF, 4'h1, 4'h0});
        vb.push_back('{1'b0, 4'hF, 2, 4'hF, 4'h0, 4'h0});

        rst_a = 1'b1; in_a = 4'h0;
        rst_b = 1'b1; in_b = 4'hF;

        run_table(1'b0, "A", va);

        // Hand sequence: ch1 toggling every cycle never gets 3 consecutive samples.
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b0, (c % 2 == 0) ? 4'h7 : 4'h5, 4'h5, 4'h0, 4'h0,
                 $sformatf("A_toggle%0d", c));
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 4'h5, 4'h5, 4'h0, 4'h0, $sformatf("A_toggle_tail%0d", c));
        end

        run_table(1'b1, "B", vb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sync_filter.md
Name: spi_sync_filter

Overview:
- Multi-channel, parametrised input conditioner for asynchronous SPI and control pins entering the FPGA clock domain.
- Each channel has three parts:
  - a STAGES-deep flip-flop synchroniser;
  - a glitch filter that passes a level only after FILTER_LEN consecutive matching samples;
  - registered one-cycle rise and fall pulses.
- Sits between the FPGA pins and the SPI slave/decoder logic, which consumes the clean levels and the edge strobes directly.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchroniser depth. STAGES < 2 is an elaboration error.
- FILTER_LEN, 3, number of consecutive differing synced samples needed to change the output. 1 means no filtering; FILTER_LEN < 1 is an elaboration error.
- RESET_VAL, {WIDTH{1'b0}}, per-channel reset level for the synchroniser flops and sync_out.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- async_in  in  WIDTH  asynchronous inputs, one bit per channel.
- sync_out  out  WIDTH  synchronised, filtered level.
- rise  out  WIDTH  one-cycle pulse when sync_out[i] goes 0->1.
- fall  out  WIDTH  one-cycle pulse when sync_out[i] goes 1->0.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - every synchroniser flop and sync_out <= RESET_VAL;
  - all filter counters <= 0;
  - rise, fall <= 0.
  - Reset overrides every other update in that cycle.
  - Reset loads the synchroniser chain with RESET_VAL, so release never produces a spurious edge from reset contents.
- Synchroniser, per channel: s[0] <= async_in[i]; s[k] <= s[k-1]. The synced value is s[STAGES-1]. No logic sits between s[0] and s[1].
- Filter, per channel, with counter cnt of width $clog2(FILTER_LEN+1):
  - If synced == sync_out[i]: cnt <= 0, and sync_out holds.
  - Else if cnt == FILTER_LEN-1: sync_out[i] <= synced and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any sample equal to sync_out restarts the count, so the count is strictly consecutive.
- Edge pulses, registered on the same edge as the sync_out update:
  - rise[i] <= 1 when sync_out[i] goes 0->1;
  - fall[i] <= 1 when sync_out[i] goes 1->0;
  - otherwise both are 0.
  - A pulse is high for exactly the first cycle in which the new sync_out is visible. Rise and fall are never high together on one channel.
- Latency: suppose async_in[i] changes before edge E1 and holds. Then sync_out[i] and its pulse update at edge E(STAGES+FILTER_LEN), counting E1 as edge 1.
- Glitch rejection: a level held for fewer than FILTER_LEN synced samples produces no sync_out change and no pulse.
- Channels are fully independent. Simultaneous events on different channels update in the same cycle without interaction.
- Reset mid-count discards the partial count; no pulse is generated.
- Minimum output pulse/interval: sync_out[i] cannot change more often than once every FILTER_LEN cycles.

Test Plan:
All scenarios use WIDTH=4, STAGES=2, FILTER_LEN=3 unless stated.
1. Reset release: hold rst=1 for 2 cycles with async_in=4'hF, then release.
   - During reset: sync_out=4'h0, rise=fall=0.
   - sync_out=4'hF and rise=4'hF for exactly one cycle at the 5th edge after release; rise=0 thereafter.
2. Clean step: async_in[0] goes 0->1 and holds.
   - sync_out[0]=1 at edge 5 with rise[0]=1 for one cycle.
   - Return 1->0: fall[0]=1 for one cycle, 5 edges later.
   - rise[3:1] and fall[3:1] stay 0 throughout.
3. Glitch: async_in[1] high for 2 cycles, then low.
   - sync_out[1] stays 0 with no pulses.
   - Repeat with 3 cycles high: sync_out[1] is high for exactly 3 cycles and rise[1]/fall[1] each pulse once.
4. Simultaneous: async_in[2] goes 0->1 and async_in[3] goes 1->0 (from steady state) on the same edge.
   - rise[2] and fall[3] pulse in the same cycle; other bits are 0.
5. Reset mid-filter: async_in[0] goes high; assert rst on the edge where cnt=2.
   - Next cycle: sync_out=0, cnt=0, no rise.
   - After release with the input still high: rise occurs 5 edges later.
6. Alternate build STAGES=3, FILTER_LEN=1, RESET_VAL=4'hF:
   - After reset sync_out=4'hF.
   - async_in[0] goes 1->0: sync_out[0]=0 and fall[0]=1 at edge 4.
   - A 1-cycle low pulse passes through as a 1-cycle low on sync_out[0].
